// File: rtl/tile_pkg.sv
// Shared constants and FSM state type for the tile line fetch path.
// Imported by the line fetcher and its pixel unpacker.
package tile_pkg;

    localparam int TILE_DIM       = 32;
    localparam int PIX_BITS       = 4;
    localparam int PIX_PER_WORD   = 8;
    localparam int WORDS_PER_TROW = 4;
    localparam int TB_AW          = 9;
    localparam int TG_AW          = 11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_TB = 3'd1,
        WT_TB = 3'd2,
        RD_TG = 3'd3,
        WT_TG = 3'd4,
        SHIFT = 3'd5,
        FIN   = 3'd6
    } fetch_state_t;

endpackage

// File: rtl/pixel_unpacker.sv
// Splits one 32-bit tile graphics word into eight 4-bit pixel codes,
// leftmost pixel (LSB nibble) first, over a registered valid/ready output.
module pixel_unpacker
    import tile_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [31:0]         load_data,
    input  logic                pix_ready,
    output logic                pix_valid,
    output logic [PIX_BITS-1:0] pix_data,
    output logic                word_done
);

    localparam logic [2:0] LAST_PIX = 3'(PIX_PER_WORD - 1);

    logic [31-PIX_BITS:0] shreg_r;
    logic [PIX_BITS-1:0]  data_r;
    logic                 valid_r;
    logic [2:0]           cnt_r;
    logic                 hs_s;

    assign hs_s      = valid_r && pix_ready;
    assign word_done = hs_s && (cnt_r == LAST_PIX);
    assign pix_valid = valid_r;
    assign pix_data  = data_r;

    // Load a word, then step one nibble per accepted pixel; output only moves on a handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_r <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            cnt_r   <= 3'd0;
        end else if (load) begin
            shreg_r <= load_data[31:PIX_BITS];
            data_r  <= load_data[PIX_BITS-1:0];
            valid_r <= 1'b1;
            cnt_r   <= 3'd0;
        end else if (hs_s) begin
            if (cnt_r == LAST_PIX) begin
                valid_r <= 1'b0;
            end else begin
                data_r  <= shreg_r[PIX_BITS-1:0];
                shreg_r <= {{PIX_BITS{1'b0}}, shreg_r[31-PIX_BITS:PIX_BITS]};
            end
            cnt_r <= cnt_r + 3'd1;
        end
    end

endmodule

// File: rtl/tile_line_fetcher.sv
// Walks the tile entries of one scanline, fetches their graphics words and
// streams the unpacked pixel codes to the line compositor.
module tile_line_fetcher
    import tile_pkg::*;
#(
    parameter int TILES_X = 20,
    parameter int TILES_Y = 15
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [8:0]       line_y,
    output logic             busy,
    output logic             done,
    output logic             tb_rw,
    output logic [TB_AW-1:0] tb_addr,
    input  logic [31:0]      tb_rdata,
    output logic             tg_rw,
    output logic [TG_AW-1:0] tg_addr,
    input  logic [31:0]      tg_rdata,
    output logic             pix_valid,
    output logic [3:0]       pix_data,
    input  logic             pix_ready
);

    localparam logic [8:0]       LINES     = 9'(TILES_Y * TILE_DIM);
    localparam logic [TB_AW-1:0] TILES_X_W = TB_AW'(TILES_X);
    localparam logic [4:0]       LAST_COL  = 5'(TILES_X - 1);
    localparam logic [1:0]       LAST_WORD = 2'(WORDS_PER_TROW - 1);

    fetch_state_t     state_r, state_nxt_s;
    logic [4:0]       col_r;
    logic [1:0]       word_r;
    logic [4:0]       yoff_r;
    logic [3:0]       idx_r;
    logic [TB_AW-1:0] tb_addr_r;
    logic [TG_AW-1:0] tg_addr_r;
    logic             busy_r, done_r;
    logic [TB_AW-1:0] row_base_s;
    logic             start_ok_s, word_done_s, last_word_s, last_col_s;
    logic             latch_s, idx_cap_s, load_s, word_adv_s, col_adv_s;

    assign start_ok_s  = (state_r == IDLE) && start && (line_y < LINES);
    assign row_base_s  = {5'd0, line_y[8:5]} * TILES_X_W;
    assign last_word_s = (word_r == LAST_WORD);
    assign last_col_s  = (col_r == LAST_COL);

    assign tb_rw   = 1'b0;
    assign tg_rw   = 1'b0;
    assign tb_addr = tb_addr_r;
    assign tg_addr = tg_addr_r;
    assign busy    = busy_r;
    assign done    = done_r;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s) state_nxt_s = RD_TB;
                else            state_nxt_s = IDLE;
            end
            RD_TB: state_nxt_s = WT_TB;
            WT_TB: state_nxt_s = RD_TG;
            RD_TG: state_nxt_s = WT_TG;
            WT_TG: state_nxt_s = SHIFT;
            SHIFT: begin
                if (!word_done_s)      state_nxt_s = SHIFT;
                else if (!last_word_s) state_nxt_s = RD_TG;
                else if (!last_col_s)  state_nxt_s = RD_TB;
                else                   state_nxt_s = FIN;
            end
            FIN:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Per-state datapath strobes
    always_comb begin
        latch_s    = 1'b0;
        idx_cap_s  = 1'b0;
        load_s     = 1'b0;
        word_adv_s = 1'b0;
        col_adv_s  = 1'b0;
        case (state_r)
            IDLE:  latch_s   = start_ok_s;
            WT_TB: idx_cap_s = 1'b1;
            WT_TG: load_s    = 1'b1;
            SHIFT: begin
                if (word_done_s) begin
                    word_adv_s = !last_word_s;
                    col_adv_s  = last_word_s && !last_col_s;
                end else begin
                    word_adv_s = 1'b0;
                    col_adv_s  = 1'b0;
                end
            end
            default: latch_s = 1'b0;
        endcase
    end

    // Line position, memory addresses and status flags; addresses are set one state ahead of use
    always_ff @(posedge clk) begin
        if (reset) begin
            col_r     <= 5'd0;
            word_r    <= 2'd0;
            yoff_r    <= 5'd0;
            idx_r     <= 4'd0;
            tb_addr_r <= '0;
            tg_addr_r <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != IDLE) && (state_nxt_s != FIN);
            done_r <= (state_nxt_s == FIN);
            if (latch_s) begin
                yoff_r    <= line_y[4:0];
                col_r     <= 5'd0;
                word_r    <= 2'd0;
                tb_addr_r <= row_base_s;
            end else if (col_adv_s) begin
                col_r     <= col_r + 5'd1;
                word_r    <= 2'd0;
                tb_addr_r <= tb_addr_r + 9'd1;
            end else if (word_adv_s) begin
                word_r    <= word_r + 2'd1;
                tg_addr_r <= {idx_r, yoff_r, word_r + 2'd1};
            end else if (idx_cap_s) begin
                idx_r     <= tb_rdata[3:0];
                tg_addr_r <= {tb_rdata[3:0], yoff_r, word_r};
            end
        end
    end

    pixel_unpacker u_unpacker (
        .clk       (clk),
        .reset     (reset),
        .load      (load_s),
        .load_data (tg_rdata),
        .pix_ready (pix_ready),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .word_done (word_done_s)
    );

endmodule
